// File: rtl/lc3_prefetch_queue.sv
// lc3_prefetch_queue
//   Instruction prefetch unit for the LC3 pipeline. Keeps up to DEPTH fetched
//   words (with their next-PC) in a circular queue, issues sequential reads to
//   the instruction memory, and redirects on br_taken. A read that is already
//   outstanding when a redirect arrives cannot be aborted, so it is drained
//   and its data dropped.
//
//   Optional build macro: LC3_PFQ_BYPASS_EN
//     When defined, a word returning on the current path while the queue is
//     empty is presented on instr/npc_out in the same cycle, and a same-cycle
//     enable_fetch consumes it without writing the queue.
//
//   Ports:
//     clock, reset       rising-edge clock, synchronous active-high reset
//     pc, instrmem_rd    memory read address / request (pc stable while high)
//     Instr_dout         memory read data
//     complete_instr     memory completion for the outstanding read
//     enable_fetch       consumer pop (effective only when instr_valid)
//     br_taken, taddr    redirect request and target
//     instr_valid        head entry valid
//     instr, npc_out     head instruction and its address + 1
//     count              occupied queue entries, 0..DEPTH
module lc3_prefetch_queue #(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = 16'h3000
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [AW-1:0]          pc,
  output logic                   instrmem_rd,
  input  logic [DW-1:0]          Instr_dout,
  input  logic                   complete_instr,
  input  logic                   enable_fetch,
  input  logic                   br_taken,
  input  logic [AW-1:0]          taddr,
  output logic                   instr_valid,
  output logic [DW-1:0]          instr,
  output logic [AW-1:0]          npc_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] fetch_ptr;
  logic [AW-1:0] fetch_ptr_nxt;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] pc_inc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_nxt;
  logic          cur_done;
  logic          bypass;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic [DW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_npc   [DEPTH];

  assign pc_inc = pc + AW'(1);

  // Queue push/pop decisions and next occupancy; a redirect overrides both.
  always_comb begin
    cur_done = (state == REQ) && complete_instr && !br_taken;
`ifdef LC3_PFQ_BYPASS_EN
    bypass = cur_done && (count == '0) && !reset;
`else
    bypass = 1'b0;
`endif
    bypass_take = bypass && enable_fetch;
    push = cur_done && !bypass_take;
    pop  = enable_fetch && (count != '0) && !br_taken;
    if (br_taken) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + CW'(push) - CW'(pop);
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic. Back-to-back requests continue only while the
  // queue will still have room after this cycle's push and pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (br_taken || (count < FULL)) state_nxt = REQ;
        else                            state_nxt = IDLE;
      end
      REQ: begin
        if (complete_instr) begin
          if (br_taken || (count_nxt < FULL)) state_nxt = REQ;
          else                                state_nxt = IDLE;
        end else if (br_taken) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (complete_instr) state_nxt = REQ;
        else                state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: a read is outstanding in both REQ and DRAIN.
  always_comb begin
    instrmem_rd = (state == REQ) || (state == DRAIN);
  end

  // Fetch pointer and request address. pc only moves when a new request
  // starts, so it stays stable across a stalled or draining read.
  always_comb begin
    if (br_taken) begin
      fetch_ptr_nxt = taddr;
    end else if (cur_done) begin
      fetch_ptr_nxt = pc_inc;
    end else begin
      fetch_ptr_nxt = fetch_ptr;
    end
    if ((state_nxt == REQ) && ((state != REQ) || complete_instr)) begin
      pc_nxt = fetch_ptr_nxt;
    end else begin
      pc_nxt = pc;
    end
  end

  // Address registers, queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      fetch_ptr <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      pc        <= pc_nxt;
      fetch_ptr <= fetch_ptr_nxt;
      count     <= count_nxt;
      if (br_taken) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
      end
    end
  end

  // Queue storage; the next-PC is stored so the head needs no adder.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      q_instr[tail] <= Instr_dout;
      q_npc[tail]   <= pc_inc;
    end
  end

  // Head presentation; zeros when nothing is valid.
  always_comb begin
    if (bypass) begin
      instr_valid = 1'b1;
      instr       = Instr_dout;
      npc_out     = pc_inc;
    end else if (count != '0) begin
      instr_valid = 1'b1;
      instr       = q_instr[head];
      npc_out     = q_npc[head];
    end else begin
      instr_valid = 1'b0;
      instr       = '0;
      npc_out     = '0;
    end
  end

endmodule

// File: tb/tb_lc3_prefetch_queue.sv
// Testbench for lc3_prefetch_queue: memory responder with programmable
// latency, scoreboard of expected {npc, instr} loaded on each reset/redirect
// and checked on every observed pop.
module tb_lc3_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        enable_fetch;
  logic        br_taken;
  logic [15:0] taddr;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] npc_out;
  logic [2:0]  count;

  int          total;
  int          bad;
  int          pop_cnt;
  logic [15:0] last_npc;
  int          mem_lat;
  bit          mem_on;
  int          wait_cnt;
  logic [31:0] exp_q[$];

  lc3_prefetch_queue #(.DW(16), .AW(16), .DEPTH(DEPTH), .RESET_PC(16'h3000)) dut (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .enable_fetch(enable_fetch), .br_taken(br_taken), .taddr(taddr),
    .instr_valid(instr_valid), .instr(instr), .npc_out(npc_out), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1F2E;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_load(input logic [15:0] a, input int n);
    logic [15:0] x;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      x = a + 16'(i);
      exp_q.push_back({x + 16'd1, mem_word(x)});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},    32'(pc),          32'h3000);
    check({tag, "_rd"},    32'(instrmem_rd), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(instr),       32'd0);
    check({tag, "_npc"},   32'(npc_out),     32'd0);
    check({tag, "_count"}, 32'(count),       32'd0);
  endtask

  task automatic wait_pop(input string tag);
    int start;
    start = pop_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      #2;
      if (pop_cnt != start) break;
    end
    check(tag, 32'(pop_cnt != start), 32'd1);
  endtask

  task automatic wait_rd(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #2;
      if (instrmem_rd) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Memory responder: completes a held request after mem_lat wait cycles.
  initial begin
    wait_cnt = 0;
    forever begin
      @(negedge clock);
      if (mem_on) begin
        if (instrmem_rd) begin
          if (wait_cnt >= mem_lat) begin
            complete_instr = 1'b1;
            Instr_dout     = mem_word(pc);
            wait_cnt       = 0;
          end else begin
            complete_instr = 1'b0;
            wait_cnt++;
          end
        end else begin
          complete_instr = 1'b0;
          wait_cnt       = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Pop monitor: every accepted pop is compared against the scoreboard head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #1;
      if (!reset && enable_fetch && instr_valid && !br_taken) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pop_instr", 32'(instr),   32'(e[15:0]));
          check("pop_npc",   32'(npc_out), 32'(e[31:16]));
        end
        last_npc = npc_out;
        pop_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    int  start;
    int  maxc;
    bit  found;
    bit  seen;
    total = 0; bad = 0; pop_cnt = 0; last_npc = 16'd0;
    reset = 1'b1; br_taken = 1'b0; enable_fetch = 1'b0; taddr = 16'd0;
    complete_instr = 1'b0; Instr_dout = 16'd0; mem_on = 1'b1; mem_lat = 0;

    // Reset state, then fill with zero-wait memory and no consumer.
    repeat (3) step();
    @(negedge clock);
    #2;
    check_reset_vals("rst");
    step();
    sb_load(16'h3000, 64);
    reset = 1'b0;
    n = -1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #2;
      if (instrmem_rd) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    check("first_rd_seen", 32'(found), 32'd1);
    check("first_rd_cycle", 32'(n), 32'd1);
    check("first_pc", 32'(pc), 32'h3000);
    repeat (8) @(negedge clock);
    #2;
    check("fill_count", 32'(count), 32'd4);
    check("fill_rd", 32'(instrmem_rd), 32'd0);
    check("fill_valid", 32'(instr_valid), 32'd1);
    check("fill_instr", 32'(instr), 32'(mem_word(16'h3000)));
    check("fill_npc", 32'(npc_out), 32'h3001);

    // Streaming: consumer always ready, one pop per cycle after fill.
    reset = 1'b1;
    repeat (3) step();
    sb_load(16'h3000, 64);
    enable_fetch = 1'b1;
    reset = 1'b0;
    start = pop_cnt;
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #2;
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("tp_max_count", 32'(maxc), 32'd1);
    check("tp_pops", 32'(pop_cnt - start), 32'd18);

    // Redirect during a slow read: old word drained and dropped.
    step();
    reset = 1'b1;
    enable_fetch = 1'b0;
    mem_lat = 3;
    repeat (3) step();
    sb_load(16'h3000, 64);
    reset = 1'b0;
    wait_rd("slow_rd_seen");
    step();
    br_taken = 1'b1;
    taddr = 16'h4000;
    sb_load(16'h4000, 64);
    step();
    br_taken = 1'b0;
    @(negedge clock);
    #2;
    check("drain_count", 32'(count), 32'd0);
    check("drain_rd", 32'(instrmem_rd), 32'd1);
    check("drain_pc", 32'(pc), 32'h3000);
    check("drain_valid", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #2;
      if (pc != 16'h3000) begin
        found = 1'b1;
        break;
      end
    end
    check("redir_pc_moved", 32'(found), 32'd1);
    check("redir_pc", 32'(pc), 32'h4000);
    check("redir_rd", 32'(instrmem_rd), 32'd1);
    step();
    enable_fetch = 1'b1;
    wait_pop("redir_pop");
    check("redir_first_npc", 32'(last_npc), 32'h4001);

    // Redirect coincident with completion and pop on a filling queue.
    step();
    reset = 1'b1;
    enable_fetch = 1'b0;
    repeat (3) step();
    mem_lat = 0;
    sb_load(16'h3000, 64);
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (count == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("near_full_seen", 32'(found), 32'd1);
    br_taken = 1'b1;
    enable_fetch = 1'b1;
    taddr = 16'h5000;
    sb_load(16'h5000, 64);
    step();
    br_taken = 1'b0;
    enable_fetch = 1'b0;
    @(negedge clock);
    #2;
    check("brc_count", 32'(count), 32'd0);
    check("brc_valid", 32'(instr_valid), 32'd0);
    check("brc_rd", 32'(instrmem_rd), 32'd1);
    check("brc_pc", 32'(pc), 32'h5000);
    step();
    enable_fetch = 1'b1;
    wait_pop("brc_pop");
    check("brc_first_npc", 32'(last_npc), 32'h5001);

    // Address wrap at 0xFFFF and queue pointer wrap under random consumption.
    step();
    br_taken = 1'b1;
    taddr = 16'hFFFE;
    sb_load(16'hFFFE, 64);
    step();
    br_taken = 1'b0;
    start = pop_cnt;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      #2;
      if (instrmem_rd && (pc == 16'h0000)) seen = 1'b1;
      if (pop_cnt - start >= 3 * DEPTH + 2) break;
      step();
      enable_fetch = 1'($urandom_range(0, 1));
    end
    check("wrap_pops_done", 32'(pop_cnt - start >= 3 * DEPTH + 2), 32'd1);
    check("wrap_pc_seen", 32'(seen), 32'd1);

    // Reset during an outstanding read with completion pulsing.
    step();
    reset = 1'b1;
    enable_fetch = 1'b0;
    repeat (3) step();
    mem_lat = 3;
    reset = 1'b0;
    wait_rd("midrst_rd_seen");
    step();
    mem_on = 1'b0;
    reset = 1'b1;
    complete_instr = 1'b1;
    Instr_dout = 16'hDEAD;
    step();
    step();
    complete_instr = 1'b0;
    @(negedge clock);
    #2;
    check_reset_vals("midrst");
    step();
    mem_on = 1'b1;
    mem_lat = 0;
    sb_load(16'h3000, 64);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    #2;
    check("post_rst_count", 32'(count), 32'd4);
    check("post_rst_instr", 32'(instr), 32'(mem_word(16'h3000)));
    check("post_rst_npc", 32'(npc_out), 32'h3001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
